// File: rtl/wptr_full_lvl.sv
// Write-domain pointer, full, fill-level and almost-full generator for an asynchronous FIFO.
// Optional sticky overflow flag is enabled by defining WPTR_OVF_EN.
module wptr_full_lvl #(
    parameter int ADDRWIDTH    = 4,
    parameter int AFULL_THRESH = (1 << ADDRWIDTH) - 4
) (
    input  logic                 wclk,
    input  logic                 wreset,
    input  logic                 winc,
    input  logic [ADDRWIDTH:0]   wq2rptr,
    output logic [ADDRWIDTH:0]   wptr,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDRWIDTH:0]   wlevel,
    input  logic                 wclr_ovf,
    output logic                 woverflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_afull;

    logic          w_we;
    logic [PW-1:0] w_bnext;
    logic [PW-1:0] w_gnext;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_full_ptr;
    logic [PW-1:0] w_level_next;

    assign w_we    = winc & ~r_full;
    assign w_bnext = r_bin + PW'(w_we);
    assign w_gnext = w_bnext ^ (w_bnext >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(wq2rptr >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign w_full_ptr   = {~wq2rptr[PW-1:PW-2], wq2rptr[PW-3:0]};
    assign w_level_next = w_bnext - w_rbin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge wclk) begin
        if (wreset) begin
            r_bin   <= '0;
            r_wptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
        end else begin
            r_bin   <= w_bnext;
            r_wptr  <= w_gnext;
            r_level <= w_level_next;
            r_full  <= (w_gnext == w_full_ptr);
            r_afull <= (w_level_next >= AFULL_LVL);
        end
    end

`ifdef WPTR_OVF_EN
    logic r_ovf;

    // A rejected write in the same cycle as a clear leaves the flag set.
    always_ff @(posedge wclk) begin
        if (wreset) begin
            r_ovf <= 1'b0;
        end else if (winc & r_full) begin
            r_ovf <= 1'b1;
        end else if (wclr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign woverflow = r_ovf;
`else
    logic w_unused_clr;

    assign w_unused_clr = wclr_ovf;
    assign woverflow    = 1'b0;
`endif

    assign wptr         = r_wptr;
    assign waddr        = r_bin[ADDRWIDTH-1:0];
    assign wfull        = r_full;
    assign walmost_full = r_afull;
    assign wlevel       = r_level;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Self-checking bench for wptr_full_lvl: randomized and directed stimulus against
// an integer write/read-count reference model of the FIFO occupancy.
module tb_wptr_full_lvl;

    localparam int AW  = 4;
    localparam int PW  = AW + 1;
    localparam int DEP = 1 << AW;
    localparam int AFT = 12;

`ifdef WPTR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          wclk;
    logic          wreset;
    logic          winc;
    logic [PW-1:0] wq2rptr;
    logic [PW-1:0] wptr;
    logic [AW-1:0] waddr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          wclr_ovf;
    logic          woverflow;

    wptr_full_lvl #(.ADDRWIDTH(AW), .AFULL_THRESH(AFT)) dut (
        .wclk        (wclk),
        .wreset      (wreset),
        .winc        (winc),
        .wq2rptr     (wq2rptr),
        .wptr        (wptr),
        .waddr       (waddr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .wclr_ovf    (wclr_ovf),
        .woverflow   (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Reference model: total writes accepted and total reads seen, as plain integers.
    int unsigned m_w;
    int unsigned m_r;
    bit          m_full;
    bit          m_af;
    int          m_lvl;
    bit          m_ovf;

    int n_vec;
    int n_err;

    function automatic logic [PW-1:0] gray(input int unsigned b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [16:0] exp_vec();
        logic [PW-1:0] lv;
        lv = PW'(m_lvl);
        return {gray(m_w), AW'(m_w), m_full, m_af, lv, m_ovf};
    endfunction

    function automatic logic [16:0] act_vec();
        return {wptr, waddr, wfull, walmost_full, wlevel, woverflow};
    endfunction

    task automatic do_cycle(input bit w, input bit clr);
        bit acc;
        bit rej;
        winc     = w;
        wclr_ovf = clr;
        wq2rptr  = gray(m_r);
        acc = w && !m_full;
        rej = w && m_full;
        @(posedge wclk);
        if (acc) m_w++;
        m_lvl  = int'(m_w - m_r);
        m_full = (m_lvl == DEP);
        m_af   = (m_lvl >= AFT);
        if (OVF_EN) begin
            if (rej) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(negedge wclk);
    endtask

    task automatic do_reset(input int cycles);
        wreset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            winc     = 1'($urandom);
            wclr_ovf = 1'($urandom);
            @(posedge wclk);
            @(negedge wclk);
        end
        wreset   = 1'b0;
        winc     = 1'b0;
        wclr_ovf = 1'b0;
        m_w = 0; m_r = 0; m_full = 0; m_af = 0; m_lvl = 0; m_ovf = 0;
        wq2rptr = '0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_vec++;
        if (act_vec() !== 17'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", act_vec(), 17'h0);
        end
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0);
        do_reset(1);
        n_vec++;
        if (act_vec() !== 17'h0 || waddr !== '0) begin
            n_err++;
            $display("FAIL reset_midfill: got %h expected %h", act_vec(), 17'h0);
        end
    endtask

    task automatic test_fill();
        do_reset(1);
        for (int i = 0; i < DEP; i++) begin
            n_vec++;
            if (waddr !== AW'(i)) begin
                n_err++;
                $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, waddr, i);
            end
            do_cycle(1'b1, 1'b0);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL fill_vec[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
            if (i == AFT - 2 || i == AFT - 1) begin
                n_vec++;
                if (walmost_full !== (i == AFT - 1)) begin
                    n_err++;
                    $display("FAIL fill_afull[%0d]: got %b expected %b", i, walmost_full, i == AFT - 1);
                end
            end
        end
        n_vec++;
        if (wfull !== 1'b1 || wptr !== 5'b11000 || wlevel !== 5'd16) begin
            n_err++;
            $display("FAIL fill_full: got full=%b wptr=%b lvl=%0d expected 1 11000 16", wfull, wptr, wlevel);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0);
            n_vec++;
            if (wptr !== 5'b11000 || wlevel !== 5'd16 || woverflow !== OVF_EN) begin
                n_err++;
                $display("FAIL ovf_hold[%0d]: got wptr=%b lvl=%0d ovf=%b expected 11000 16 %b",
                         i, wptr, wlevel, woverflow, OVF_EN);
            end
        end
        do_cycle(1'b0, 1'b1);
        n_vec++;
        if (woverflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got %b expected 0", woverflow);
        end
        do_cycle(1'b1, 1'b1);
        n_vec++;
        if (woverflow !== OVF_EN || act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL ovf_set_wins: got %h expected %h", act_vec(), exp_vec());
        end
        do_cycle(1'b0, 1'b1);
    endtask

    task automatic test_drain();
        m_r = 1;
        do_cycle(1'b0, 1'b0);
        n_vec++;
        if (wfull !== 1'b0 || wlevel !== 5'd15 || wq2rptr !== 5'b00001) begin
            n_err++;
            $display("FAIL drain_release: got full=%b lvl=%0d expected 0 15", wfull, wlevel);
        end
        for (int i = 2; i <= 5; i++) begin
            m_r = i;
            do_cycle(1'b0, 1'b0);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL drain_step[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (wlevel !== 5'd11 || walmost_full !== 1'b0) begin
            n_err++;
            $display("FAIL drain_afull: got lvl=%0d af=%b expected 11 0", wlevel, walmost_full);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0);
        m_r++;
        do_cycle(1'b1, 1'b0);
        n_vec++;
        if (wlevel !== 5'd15 || wfull !== 1'b0 || act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL simultaneous: got lvl=%0d full=%b expected 15 0", wlevel, wfull);
        end
    endtask

    task automatic test_wrap();
        bit            seen_wrap;
        logic [PW-1:0] prev;
        do_reset(1);
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0);
        seen_wrap = 1'b0;
        prev = wptr;
        for (int i = 0; i < 40; i++) begin
            m_r++;
            do_cycle(1'b1, 1'b0);
            if (prev == 5'b10000 && wptr == 5'b00000) seen_wrap = 1'b1;
            prev = wptr;
            n_vec++;
            if (wlevel !== 5'd8 || wfull !== 1'b0 || act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_vec++;
        if (!seen_wrap) begin
            n_err++;
            $display("FAIL wrap_seen: got 0 expected 1 (10000 -> 00000 transition)");
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            if (m_r < m_w && $urandom_range(0, 1) == 1) m_r++;
            do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        wreset = 1'b1; winc = 1'b0; wclr_ovf = 1'b0; wq2rptr = '0;
        m_w = 0; m_r = 0; m_full = 0; m_af = 0; m_lvl = 0; m_ovf = 0;
        @(negedge wclk);
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
